// File: rtl/life_ctrl_pkg.sv
// Shared types and geometry for the 16x16 Life array controller.
package life_ctrl_pkg;
  localparam int ROWS  = 16;
  localparam int ROW_W = 16;
  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_STEP = 3'd3,
    ST_READ = 3'd4
  } state_t;
endpackage

// File: rtl/life_step_timer.sv
// Inter-generation countdown: loads max(value,1), counts down, expires at 1.
module life_step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_value == '0) ? W'(1) : load_value;
    end else if (count && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));
endmodule

// File: rtl/life_controller_16x16.sv
// Sequences pattern load, generation stepping and row readout for a 16x16 Life array.
module life_controller_16x16
  import life_ctrl_pkg::*;
#(
  parameter int PERIOD_W       = 16,
  parameter int GEN_W          = 16,
  parameter bit HALT_ON_STABLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [ROW_W-1:0]    load_data,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                run,
  input  logic                single,
  input  logic [PERIOD_W-1:0] period,
  output logic [ROW_W-1:0]    arr_vali,
  output logic [SEL_W-1:0]    arr_vali_selector,
  output logic                arr_write_enb,
  output logic                arr_step,
  output logic [SEL_W-1:0]    arr_valo_selector,
  input  logic [ROW_W-1:0]    arr_valo,
  input  logic [ROW_W-1:0]    arr_valo_prev,
  output logic [ROW_W-1:0]    row_data,
  output logic [SEL_W-1:0]    row_idx,
  output logic                row_last,
  output logic                row_valid,
  input  logic                row_ready,
  output logic                stable,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy,
  output state_t              fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its data stay constant until that transfer.
  state_t           state, state_next;
  logic [SEL_W-1:0] row_cnt;
  logic             acc;
  logic             halted;
  logic             load_fire, read_fire, last_row, new_stable;
  logic             timer_load, timer_expire;

  assign last_row   = (row_cnt == SEL_W'(ROWS - 1));
  assign load_fire  = (state == ST_LOAD) && load_valid;
  assign read_fire  = (state == ST_READ) && row_ready;
  assign new_stable = acc & (arr_valo == arr_valo_prev);
  assign timer_load = (state == ST_READ) && (state_next == ST_WAIT);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load_start)                     state_next = ST_LOAD;
        else if (single || (run && !halted)) state_next = ST_STEP;
      end
      ST_LOAD: if (load_fire && last_row) state_next = ST_IDLE;
      ST_STEP: state_next = ST_READ;
      ST_READ: begin
        if (read_fire && last_row)
          state_next = (run && !(HALT_ON_STABLE && new_stable)) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!run)              state_next = ST_IDLE;
        else if (timer_expire) state_next = ST_STEP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      acc       <= 1'b0;
      halted    <= 1'b0;
      stable    <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && state_next == ST_LOAD) begin
        row_cnt   <= '0;
        gen_count <= '0;
        stable    <= 1'b0;
      end
      if (load_fire) row_cnt <= row_cnt + SEL_W'(1);
      if (state == ST_STEP) begin
        gen_count <= gen_count + GEN_W'(1);
        row_cnt   <= '0;
        acc       <= 1'b1;
      end
      if (read_fire) begin
        row_cnt <= row_cnt + SEL_W'(1);
        acc     <= new_stable;
        if (last_row) stable <= new_stable;
      end
      // A halt on a stable generation holds off free-run until run is dropped.
      if (!run) halted <= 1'b0;
      else if (read_fire && last_row && state_next == ST_IDLE) halted <= 1'b1;
    end
  end

  life_step_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (period),
    .count      (state == ST_WAIT),
    .expire     (timer_expire)
  );

  assign load_ready        = (state == ST_LOAD);
  assign arr_write_enb     = load_fire;
  assign arr_vali          = load_fire ? load_data : '0;
  assign arr_vali_selector = load_fire ? row_cnt : '0;
  assign arr_step          = (state == ST_STEP);
  assign row_valid         = (state == ST_READ);
  assign arr_valo_selector = row_valid ? row_cnt : '0;
  assign row_data          = row_valid ? arr_valo : '0;
  assign row_idx           = row_valid ? row_cnt : '0;
  assign row_last          = row_valid && last_row;
  assign busy              = (state != ST_IDLE);
  assign fsm_state         = state;
endmodule

// File: doc/life_controller_16x16.md
LIFE_CONTROLLER_16X16 -- requirements
Module: life_controller_16x16

Interface
REQ-001 Parameter PERIOD_W, default 16: width of the generation period input.
REQ-002 Parameter GEN_W, default 16: width of the generation counter.
REQ-003 Parameter HALT_ON_STABLE, default 1: when 1, free-run stops after a stable generation.
REQ-004 There SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 load_start  in  1  pulse; starts a 16-row pattern load.
REQ-008 load_data / load_valid / load_ready  in / in / out  16 / 1 / 1  pattern row stream, valid/ready.
REQ-009 run  in  1  level; free-running generations while high.
REQ-010 single  in  1  pulse; exactly one generation.
REQ-011 period  in  PERIOD_W  idle cycles between generations; 0 treated as 1.
REQ-012 arr_vali / arr_vali_selector / arr_write_enb  out  16 / 4 / 1  array row write port.
REQ-013 arr_step  out  1  one-cycle generation pulse to array.
REQ-014 arr_valo_selector  out  4  array read row select.
REQ-015 arr_valo / arr_valo_prev  in  16 / 16  current and previous-generation row from array (combinational from selector).
REQ-016 row_data / row_idx / row_last  out  16 / 4 / 1  readout row, index, last-row flag.
REQ-017 row_valid / row_ready  out / in  1 / 1  readout handshake.
REQ-018 stable  out  1  last completed generation equal to its predecessor.
REQ-019 gen_count  out  GEN_W  generations stepped since last load.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States SHALL be IDLE, LOAD, WAIT, STEP, READ.
REQ-022 IDLE: load_start -> LOAD (priority over run/single); else run or single -> STEP.
REQ-023 LOAD: load_ready=1; each load_valid&load_ready cycle drives arr_write_enb=1, arr_vali=load_data, arr_vali_selector=row counter, then increments counter; after row 15 -> IDLE.
REQ-024 Entering LOAD SHALL clear row counter, gen_count and stable.
REQ-025 STEP: arr_step=1 for exactly one cycle, gen_count increments (wraps modulo 2^GEN_W), -> READ.
REQ-026 READ: arr_valo_selector=row counter; row_data=arr_valo, row_idx=row counter, row_valid=1, row_last=(row counter==15); counter advances only on row_valid&row_ready.
REQ-027 READ SHALL AND (arr_valo==arr_valo_prev) into a stable accumulator on each handshake; on the row-15 handshake stable takes the final accumulator value.
REQ-028 After row-15 handshake: run high and not (HALT_ON_STABLE and new stable) -> WAIT; otherwise -> IDLE.
REQ-029 WAIT: counter loads max(period,1) on entry, decrements each cycle, -> STEP when it reaches 1; run low in WAIT -> IDLE immediately.
REQ-030 run deasserted during STEP or READ SHALL not abort; readout completes, then IDLE.
REQ-031 load_start, single outside IDLE SHALL be ignored.
REQ-032 arr_write_enb and arr_step SHALL never be high in the same cycle; both low outside LOAD/STEP.
REQ-033 row_valid SHALL hold with row_data stable until accepted.

Reset
REQ-034 reset low SHALL immediately force IDLE, all counters 0, stable=0, gen_count=0, and all outputs 0 (arr_write_enb, arr_step, load_ready, row_valid, busy deasserted).
REQ-035 Reset mid-LOAD or mid-READ SHALL discard partial progress; array contents are not cleared by this block.

Structure
REQ-036 Package life_ctrl_pkg SHALL hold the state enum, ROWS=16, ROW_W=16, SEL_W=4.
REQ-037 Period countdown SHALL be one sub-module, life_step_timer (load, count, expire).

Verification
REQ-038 Load 16 rows (row n = 16'h0001<<n) with random load_valid gaps -> 16 writes, selector 0..15, data matched, then IDLE, busy=0.
REQ-039 Blinker loaded, single pulse -> one arr_step, gen_count=1, 16 rows read, row_last on row 15, stable=0.
REQ-040 Block 2x2 loaded, run=1, period=5, HALT_ON_STABLE=1 -> one generation, stable=1, return to IDLE, gen_count=1.
REQ-041 Blinker, run=1, period=0 -> arr_step spacing equals readout length plus 1 idle cycle; row_ready held low 10 cycles -> row_data/row_idx frozen.
REQ-042 Assert reset during READ row 7 -> all outputs 0 next cycle; after release, load_start accepted, gen_count=0.
REQ-043 load_start and run same cycle in IDLE -> LOAD entered, no arr_step issued.
